// File: rtl/apb_shared_arbiter.sv
// Two-master to one-slave APB arbiter with round-robin grant and a three-state transfer FSM.
// Optional ACCESS watchdog enabled by defining APB_SHARED_ARBITER_TIMEOUT_EN.
module apb_shared_arbiter #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [1:0]                           i_m_psel,
  input  logic [1:0]                           i_m_penable,
  input  logic [1:0][ADDRESS_WIDTH-1:0]        i_m_paddr,
  input  logic [1:0]                           i_m_pwrite,
  input  logic [1:0][DATA_WIDTH-1:0]           i_m_pwdata,
  input  logic [1:0][DATA_WIDTH/8-1:0]         i_m_pstrb,
  output logic [1:0]                           o_m_pready,
  output logic [1:0][DATA_WIDTH-1:0]           o_m_prdata,
  output logic [1:0]                           o_m_pslverr,
  output logic                                 o_s_psel,
  output logic                                 o_s_penable,
  output logic [ADDRESS_WIDTH-1:0]             o_s_paddr,
  output logic                                 o_s_pwrite,
  output logic [DATA_WIDTH-1:0]                o_s_pwdata,
  output logic [DATA_WIDTH/8-1:0]              o_s_pstrb,
  input  logic                                 i_s_pready,
  input  logic                                 i_s_pslverr,
  input  logic [DATA_WIDTH-1:0]                i_s_prdata,
  output logic [1:0]                           o_grant
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t     state;
  logic [1:0] grant;
  logic       last;
  logic       gsel;
  logic       busy;
  logic       acc;
  logic       pick_m1;
  logic       expire;
  logic       unused_penable;

  // Request is psel alone; penable is only meaningful to the master's own protocol.
  assign unused_penable = ^i_m_penable;

  assign gsel    = grant[1];
  assign busy    = (state != IDLE) && !i_rst;
  assign acc     = (state == ACCESS) && !i_rst;
  assign pick_m1 = i_m_psel[1] && (!i_m_psel[0] || !last);
  assign o_grant = grant;

`ifdef APB_SHARED_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  assign expire = acc && !i_s_pready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || state != ACCESS) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|i_m_psel) begin
            grant <= pick_m1 ? 2'b10 : 2'b01;
            last  <= pick_m1;
            state <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (i_s_pready || expire) begin
            grant <= 2'b00;
            state <= IDLE;
          end
        end
        default: begin
          grant <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_s_psel    = busy;
    o_s_penable = acc;
    o_s_paddr   = '0;
    o_s_pwrite  = 1'b0;
    o_s_pwdata  = '0;
    o_s_pstrb   = '0;
    o_m_pready  = 2'b00;
    o_m_prdata  = '0;
    o_m_pslverr = 2'b00;
    if (busy) begin
      o_s_paddr  = i_m_paddr[gsel];
      o_s_pwrite = i_m_pwrite[gsel];
      o_s_pwdata = i_m_pwdata[gsel];
      o_s_pstrb  = i_m_pstrb[gsel];
    end
    // A watchdog expiry answers the master with an error and no data.
    if (acc) begin
      o_m_pready[gsel]  = i_s_pready || expire;
      o_m_pslverr[gsel] = expire ? 1'b1 : i_s_pslverr;
      o_m_prdata[gsel]  = expire ? '0 : i_s_prdata;
    end
  end

endmodule

// File: tb/tb_apb_shared_arbiter.sv
// Directed bench for apb_shared_arbiter: single transfers, round-robin, wait states, reset abort.
module tb_apb_shared_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           m_psel, m_penable, m_pwrite;
  logic [1:0][AW-1:0]   m_paddr;
  logic [1:0][DW-1:0]   m_pwdata;
  logic [1:0][SW-1:0]   m_pstrb;
  logic [1:0]           m_pready, m_pslverr;
  logic [1:0][DW-1:0]   m_prdata;
  logic                 s_psel, s_penable, s_pwrite;
  logic [AW-1:0]        s_paddr;
  logic [DW-1:0]        s_pwdata;
  logic [SW-1:0]        s_pstrb;
  logic                 s_pready, s_pslverr;
  logic [DW-1:0]        s_prdata;
  logic [1:0]           grant;

  int checks = 0;
  int failures = 0;

  apb_shared_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_psel(m_psel), .i_m_penable(m_penable), .i_m_paddr(m_paddr),
    .i_m_pwrite(m_pwrite), .i_m_pwdata(m_pwdata), .i_m_pstrb(m_pstrb),
    .o_m_pready(m_pready), .o_m_prdata(m_prdata), .o_m_pslverr(m_pslverr),
    .o_s_psel(s_psel), .o_s_penable(s_penable), .o_s_paddr(s_paddr),
    .o_s_pwrite(s_pwrite), .o_s_pwdata(s_pwdata), .o_s_pstrb(s_pstrb),
    .i_s_pready(s_pready), .i_s_pslverr(s_pslverr), .i_s_prdata(s_prdata),
    .o_grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    m_psel = '0; m_penable = '0; m_pwrite = '0;
    m_paddr = '0; m_pwdata = '0; m_pstrb = '0;
    s_pready = 1'b1; s_pslverr = 1'b0; s_prdata = '0;
    tick(); tick();
    #1;
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_spsel", 64'(s_psel), 64'h0);
    check("rst_mready", 64'(m_pready), 64'h0);

    // Single write from master 0, slave ready on first ACCESS cycle
    rst = 1'b0;
    m_psel[0] = 1'b1; m_paddr[0] = 16'h0010; m_pwrite[0] = 1'b1;
    m_pwdata[0] = 32'hA5A5A5A5; m_pstrb[0] = 4'hF;
    #1;
    check("idle_spsel", 64'(s_psel), 64'h0);
    check("idle_paddr", 64'(s_paddr), 64'h0);
    tick();
    m_penable[0] = 1'b1;
    #1;
    check("setup_psel_en", 64'({s_psel, s_penable}), 64'h2);
    check("setup_addr", 64'(s_paddr), 64'h0010);
    check("setup_wdata", 64'(s_pwdata), 64'hA5A5A5A5);
    check("setup_grant", 64'(grant), 64'h1);
    check("setup_mready", 64'(m_pready), 64'h0);
    tick();
    #1;
    check("acc_psel_en", 64'({s_psel, s_penable}), 64'h3);
    check("acc_addr_wr", 64'({s_pwrite, s_pstrb, s_paddr}), 64'h1F0010);
    check("acc_wdata", 64'(s_pwdata), 64'hA5A5A5A5);
    check("acc_mready", 64'(m_pready), 64'h1);
    m_psel[0] = 1'b0; m_penable[0] = 1'b0;
    tick();
    #1;
    check("post_idle", 64'({grant, s_psel}), 64'h0);

    // Contention right after reset: alternation 01,10,01,10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_psel = 2'b11;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant", 64'(grant), (k % 2 == 0) ? 64'h1 : 64'h2);
      check("rr_setup_mready", 64'(m_pready), 64'h0);
      tick();
      #1;
      check("rr_acc_mready", 64'(m_pready), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      #1;
      check("rr_gap_psel", 64'({grant, s_psel}), 64'h0);
      tick();
    end
    m_psel = 2'b00;
    tick(); tick();

    // Master 1 read, 5 wait states, error response
    m_psel[1] = 1'b1; m_pwrite[1] = 1'b0; m_paddr[1] = 16'h0020;
    s_pready = 1'b0;
    tick(); tick();
    for (int w = 0; w < 5; w++) begin
      #1;
      check("wait_mready", 64'(m_pready), 64'h0);
      check("wait_slave", 64'({s_penable, s_pwrite, s_paddr}), 64'h20020);
      tick();
    end
    s_pready = 1'b1; s_prdata = 32'h12345678; s_pslverr = 1'b1;
    #1;
    check("rd_mready", 64'(m_pready), 64'h2);
    check("rd_prdata1", 64'(m_prdata[1]), 64'h12345678);
    check("rd_prdata0", 64'(m_prdata[0]), 64'h0);
    check("rd_pslverr", 64'(m_pslverr), 64'h2);
    m_psel[1] = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
    tick();

    // Reset during ACCESS aborts, then a fresh master 0 transfer
    m_psel[0] = 1'b1; s_pready = 1'b0;
    tick(); tick();
    #1;
    check("abort_pre", 64'({s_psel, s_penable}), 64'h3);
    rst = 1'b1; s_pready = 1'b1;
    #1;
    check("abort_during", 64'({s_psel, m_pready}), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_after", 64'({grant, s_psel, m_pready}), 64'h0);
    tick();
    #1;
    check("reacq_grant", 64'(grant), 64'h1);
    tick();
    #1;
    check("reacq_mready", 64'(m_pready), 64'h1);
    m_psel[0] = 1'b0;
    tick();

`ifdef APB_SHARED_ARBITER_TIMEOUT_EN
    m_psel[0] = 1'b1; s_pready = 1'b0;
    tick(); tick();
    for (int c = 1; c < 8; c++) begin
      #1;
      check("to_wait", 64'(m_pready), 64'h0);
      tick();
    end
    #1;
    check("to_fire", 64'({m_pready, m_pslverr}), 64'h5);
    check("to_prdata", 64'(m_prdata), 64'h0);
    m_psel[0] = 1'b0;
    tick();
    #1;
    check("to_idle", 64'({grant, s_psel}), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_shared_arbiter.md
APB_SHARED_ARBITER -- requirements
Module: apb_shared_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit (used only with the macro in REQ-025).
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
REQ-005 SHALL have these master-side ports, index 0/1 = master 0/1:
- i_m_psel  in  2  per-master psel.
- i_m_penable  in  2  per-master penable.
- i_m_paddr  in  2xADDRESS_WIDTH  per-master address.
- i_m_pwrite  in  2  per-master write flag.
- i_m_pwdata  in  2xDATA_WIDTH  per-master write data.
- i_m_pstrb  in  2xDATA_WIDTH/8  per-master strobes.
- o_m_pready  out  2  per-master pready.
- o_m_prdata  out  2xDATA_WIDTH  per-master read data.
- o_m_pslverr  out  2  per-master error.
REQ-006 SHALL have these slave-side ports, driving the shared APB slave (the APB-to-Wishbone bridge):
- o_s_psel, o_s_penable  out  1 each  slave psel and penable.
- o_s_paddr  out  ADDRESS_WIDTH  slave address.
- o_s_pwrite  out  1  slave write flag.
- o_s_pwdata  out  DATA_WIDTH  slave write data.
- o_s_pstrb  out  DATA_WIDTH/8  slave strobes.
- i_s_pready, i_s_pslverr  in  1 each  slave pready and error.
- i_s_prdata  in  DATA_WIDTH  slave read data.
REQ-007 SHALL have o_grant  out  2  one-hot registered grant; all zeros when idle.

Function
REQ-008 SHALL treat master n as requesting when i_m_psel[n]=1, regardless of penable.
REQ-009 SHALL use a three-state FSM: IDLE, SETUP, ACCESS.
REQ-010 IDLE: if any request, load o_grant and go to SETUP next cycle; otherwise stay in IDLE.
REQ-011 SHALL arbitrate round-robin: a single requester wins; if both request, the master not granted last wins.
REQ-012 The last-granted pointer SHALL update only at grant.
REQ-013 SETUP: o_s_psel=1, o_s_penable=0 for exactly one cycle, then go to ACCESS.
REQ-014 ACCESS: o_s_psel=1, o_s_penable=1; hold until i_s_pready=1, then go to IDLE next cycle.
REQ-015 o_s_paddr/pwrite/pwdata/pstrb SHALL be combinationally muxed from the granted master in SETUP and ACCESS, and SHALL be zero in IDLE.
REQ-016 o_m_pready[g] SHALL equal i_s_pready in ACCESS for granted master g; it SHALL be 0 otherwise, so a waiting master stalls in its access phase.
REQ-017 o_m_prdata[g] and o_m_pslverr[g] SHALL forward i_s_prdata and i_s_pslverr in ACCESS; other masters and other states SHALL see zeros.
REQ-018 Minimum latency SHALL be 3 cycles (IDLE, SETUP, ACCESS) from the request being sampled in IDLE to pready, with 1 mandatory IDLE cycle between transfers.
REQ-019 If the granted master drops psel mid-transfer (protocol violation), the transfer SHALL still complete on the slave side; the response is discarded.
REQ-020 Back-to-back requests from one master with no competitor SHALL be granted consecutively.

Reset
REQ-021 On i_rst=1 at a clock edge, the FSM SHALL go to IDLE and o_grant SHALL be 0.
REQ-022 On reset, the last-granted pointer SHALL be set to master 1, so master 0 wins the first contention.
REQ-023 During reset, all o_s_* and o_m_* outputs SHALL be 0.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer: o_s_psel=0 in the following cycle and no pready to any master.

Configuration
REQ-025 With APB_SHARED_ARBITER_TIMEOUT_EN defined:
- A counter SHALL count ACCESS cycles.
- When it reaches TIMEOUT_CYCLES without i_s_pready, the granted master SHALL get o_m_pready=1 and o_m_pslverr=1 and prdata=0 for one cycle.
- The slave psel SHALL deassert and the FSM SHALL go to IDLE.
REQ-026 Without the macro, there SHALL be no counter, and ACCESS waits indefinitely.

Verification
REQ-027 Master 0 writes addr 0x0010 data 0xA5A5A5A5 with the slave pready on the first ACCESS cycle -> slave sees SETUP then ACCESS with the same values; o_m_pready[0] pulses in cycle 3; o_grant=01.
REQ-028 Both masters assert psel in the same cycle after reset -> master 0 is served first, master 1 next, with 1 IDLE cycle between; master 1 sees pready=0 throughout master 0's transfer.
REQ-029 Both masters request continuously for 4 transfers -> grants alternate 01,10,01,10.
REQ-030 Master 1 reads with the slave inserting 5 wait states and prdata 0x12345678, pslverr=1 -> master 1 gets pready, prdata 0x12345678 and pslverr=1 on the same cycle; master 0 outputs stay 0.
REQ-031 i_rst asserted during ACCESS -> the next cycle shows o_s_psel=0, o_grant=0, no pready; a later master 0 request proceeds normally.
REQ-032 With the macro and TIMEOUT_CYCLES=8, the slave never responds -> the granted master gets pready=1 and pslverr=1 after 8 ACCESS cycles, and the FSM returns to IDLE.
